// File: rtl/pqcuark_zeta_loader_pkg.sv
// pqcuark_zeta_loader_pkg: shared types, zeta geometry and completion builder for the zeta loader
// Holds the slice of the core pipeline types the loader touches (rr->exe issue, exe->wb completion),
// the zeta memory geometry and the loader state encoding.
package pqcuark_zeta_loader_pkg;

  localparam int ZETA_W      = 32;
  localparam int ZETA_IDX_W  = 8;
  localparam int ZETA_BANK_W = 8;
  localparam int ZETA_ADDR_W = ZETA_BANK_W + ZETA_IDX_W;

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, RESP} zeta_ld_state_t;

  typedef enum logic [2:0] {
    UNIT_ALU, UNIT_DIV, UNIT_MUL, UNIT_BRANCH, UNIT_MEM, UNIT_PQC_NTT
  } functional_unit_t;

  typedef enum logic [3:0] {
    ADD, SUB, MUL, LD, SD, PQC_NTT_BFU, PQC_ZETA_WR
  } instr_type_t;

  typedef enum logic [3:0] {
    INSTR_ADDR_MISALIGN = 4'd0,
    ILLEGAL_INSTR       = 4'd2,
    LD_ACCESS_FAULT     = 4'd5,
    ST_AMO_ACCESS_FAULT = 4'd7,
    NULL_EXCEPTION      = 4'd15
  } exception_cause_t;

  typedef struct packed {
    exception_cause_t cause;
    logic [63:0]      origin;
    logic             valid;
  } exception_t;

  typedef struct packed {
    logic             valid;
    logic [63:0]      pc;
    functional_unit_t unit;
    instr_type_t      instr_type;
    logic [4:0]       rd;
  } instr_entry_t;

  typedef struct packed {
    instr_entry_t instr;
    logic [63:0]  data_rs1;
    logic [63:0]  data_rs2;
    logic [5:0]   prd;
    logic         checkpoint_done;
    logic [1:0]   chkp;
    logic [5:0]   gl_index;
  } rr_exe_arith_instr_t;

  typedef struct packed {
    logic         valid;
    logic [63:0]  pc;
    instr_type_t  instr_type;
    logic [4:0]   rd;
    logic [5:0]   prd;
    logic [63:0]  result;
    logic         regfile_we;
    logic         branch_taken;
    exception_t   ex;
    logic [4:0]   fp_status;
    logic         checkpoint_done;
    logic [1:0]   chkp;
    logic [5:0]   gl_index;
  } exe_wb_scalar_instr_t;

  // Completion record prepared at accept time; result/regfile_we/branch/fp stay zero.
  function automatic exe_wb_scalar_instr_t zeta_completion(rr_exe_arith_instr_t i, logic fault);
    exe_wb_scalar_instr_t c;
    c = '0;
    c.valid           = 1'b1;
    c.pc              = i.instr.pc;
    c.instr_type      = i.instr.instr_type;
    c.rd              = i.instr.rd;
    c.prd             = i.prd;
    c.checkpoint_done = i.checkpoint_done;
    c.chkp            = i.chkp;
    c.gl_index        = i.gl_index;
    c.ex.valid        = fault;
    if (fault) begin
      c.ex.cause  = ST_AMO_ACCESS_FAULT;
      c.ex.origin = i.instr.pc;
    end
    return c;
  endfunction

endpackage

// File: rtl/pqcuark_zeta_loader.sv
// pqcuark_zeta_loader: writes two 32-bit zetas per PQC_ZETA_WR instruction into the BFU zeta memory
// Ports:
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   flush_i         kills the in-flight op; gates the write of the flush cycle
//   instruction_i   rr->exe issue (rs1 = two zetas, rs2 = {bank @39:32, idx @7:0})
//   ready_o/busy_o  loader idle / write sequence in progress
//   we_zeta_o, zeta_addr_o, zeta_data_o   zeta memory write port, addr = {bank, idx}
//   instruction_o   exe->wb completion, one cycle, no register result
module pqcuark_zeta_loader
  import pqcuark_zeta_loader_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    flush_i,
  input  rr_exe_arith_instr_t     instruction_i,
  output logic                    ready_o,
  output logic                    busy_o,
  output logic                    we_zeta_o,
  output logic [ZETA_ADDR_W-1:0]  zeta_addr_o,
  output logic [ZETA_W-1:0]       zeta_data_o,
  output exe_wb_scalar_instr_t    instruction_o
);

  zeta_ld_state_t       state_q, state_d;
  exe_wb_scalar_instr_t cmp_q;
  logic [2*ZETA_W-1:0]  rs1_q;
  logic [ZETA_BANK_W-1:0] bank_q;
  logic [ZETA_IDX_W-1:0]  idx_q;
  logic accept, addr_ok;

  assign accept = instruction_i.instr.valid && instruction_i.instr.unit == UNIT_PQC_NTT &&
                  instruction_i.instr.instr_type == PQC_ZETA_WR && state_q == IDLE && !flush_i;
  // Any bit set outside the bank and index fields makes the address illegal.
  assign addr_ok = instruction_i.data_rs2[63:40] == '0 && instruction_i.data_rs2[31:8] == '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cmp_q   <= '0;
      rs1_q   <= '0;
      bank_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cmp_q  <= zeta_completion(instruction_i, !addr_ok);
        rs1_q  <= instruction_i.data_rs1;
        bank_q <= instruction_i.data_rs2[39:32];
        idx_q  <= instruction_i.data_rs2[7:0];
      end
    end
  end

  always_comb begin
    state_d = flush_i          ? IDLE :
              state_q == IDLE  ? (accept ? (addr_ok ? WR_LO : RESP) : IDLE) :
              state_q == WR_LO ? WR_HI :
              state_q == WR_HI ? RESP : IDLE;
  end

  // The high word's index wraps inside the bank; the bank never carries.
  always_comb begin
    ready_o     = state_q == IDLE;
    busy_o      = state_q != IDLE;
    we_zeta_o   = (state_q == WR_LO || state_q == WR_HI) && !flush_i;
    zeta_addr_o = state_q == WR_LO ? {bank_q, idx_q} :
                  state_q == WR_HI ? {bank_q, idx_q + ZETA_IDX_W'(1)} : '0;
    zeta_data_o = state_q == WR_LO ? rs1_q[ZETA_W-1:0] :
                  state_q == WR_HI ? rs1_q[2*ZETA_W-1:ZETA_W] : '0;
    instruction_o       = cmp_q;
    instruction_o.valid = cmp_q.valid && state_q == RESP && !flush_i;
  end

endmodule

// File: tb/tb_pqcuark_zeta_loader.sv
// tb_pqcuark_zeta_loader: scoreboard bench for the zeta loader with a queue-based reference model
module tb_pqcuark_zeta_loader;
  import pqcuark_zeta_loader_pkg::*;

  logic clk = 0, rstn_i = 0, flush_i = 0;
  rr_exe_arith_instr_t in_i = '0;
  logic ready_o, busy_o, we_zeta_o;
  logic [15:0] zeta_addr_o;
  logic [31:0] zeta_data_o;
  exe_wb_scalar_instr_t instruction_o;

  pqcuark_zeta_loader dut (
    .clk_i(clk), .rstn_i(rstn_i), .flush_i(flush_i), .instruction_i(in_i),
    .ready_o(ready_o), .busy_o(busy_o), .we_zeta_o(we_zeta_o),
    .zeta_addr_o(zeta_addr_o), .zeta_data_o(zeta_data_o), .instruction_o(instruction_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] addr; logic [31:0] data; int cyc; } wr_t;
  typedef struct {
    logic [63:0] pc; logic [4:0] rd; logic [5:0] prd; logic [5:0] gl; logic [1:0] chkp;
    logic cd; logic exv; logic [63:0] origin; int cyc;
  } cmp_t;

  wr_t  exp_wr_q[$];
  cmp_t exp_cmp_q[$];
  int n_chk = 0, n_fail = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic rr_exe_arith_instr_t mk(logic [63:0] rs1, logic [63:0] rs2, logic [63:0] pc,
                                             functional_unit_t u, instr_type_t t);
    rr_exe_arith_instr_t x;
    x = '0;
    x.instr.valid = 1'b1;
    x.instr.pc = pc;
    x.instr.unit = u;
    x.instr.instr_type = t;
    x.instr.rd = 5'($urandom);
    x.prd = 6'($urandom);
    x.gl_index = 6'($urandom);
    x.chkp = 2'($urandom);
    x.checkpoint_done = 1'($urandom);
    x.data_rs1 = rs1;
    x.data_rs2 = rs2;
    return x;
  endfunction

  // Reference model. mode 0: expect nothing, 1: full sequence, 2: only the low write.
  task automatic push_exp(rr_exe_arith_instr_t x, int mode, int k);
    logic [63:0] r2;
    bit ok;
    int bank, idx;
    r2 = x.data_rs2;
    ok = (r2 >> 40) == 0 && ((r2 >> 8) & 64'hFF_FFFF) == 0;
    bank = int'(r2[39:32]);
    idx = int'(r2[7:0]);
    if (mode == 0) return;
    if (ok) begin
      exp_wr_q.push_back('{16'(bank * 256 + idx), x.data_rs1[31:0], k});
      if (mode == 1) exp_wr_q.push_back('{16'(bank * 256 + (idx + 1) % 256), x.data_rs1[63:32], k + 1});
    end
    if (mode == 1)
      exp_cmp_q.push_back('{x.instr.pc, x.instr.rd, x.prd, x.gl_index, x.chkp, x.checkpoint_done,
                            !ok, ok ? 64'd0 : x.instr.pc, ok ? k + 2 : k});
  endtask

  // Called at a negedge; returns just after the accepting posedge with k = that cycle number.
  task automatic issue(input rr_exe_arith_instr_t x, input int mode, output int k, output int waits);
    waits = 0;
    in_i = x;
    while (!ready_o && waits < 30) begin
      @(posedge clk);
      @(negedge clk);
      waits++;
    end
    n_chk++;
    if (!ready_o) begin
      n_fail++;
      $display("FAIL issue_timeout: ready_o %b after %0d cycles, required 1", ready_o, waits);
      k = -1;
      in_i = '0;
      return;
    end
    k = cyc + 1;
    push_exp(x, mode, k);
    @(posedge clk);
    #1 in_i = '0;
  endtask

  always @(negedge clk) begin
    wr_t w;
    cmp_t c;
    #2;
    if (rstn_i) chk("ready_vs_busy", ready_o, !busy_o);
    if (we_zeta_o) begin
      if (exp_wr_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_write: addr %h data %h at cycle %0d, required no write", zeta_addr_o, zeta_data_o, cyc);
      end else begin
        w = exp_wr_q.pop_front();
        chk("wr_addr", zeta_addr_o, w.addr);
        chk("wr_data", zeta_data_o, w.data);
        chk("wr_cycle", cyc, w.cyc);
      end
    end
    if (instruction_o.valid) begin
      if (exp_cmp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_completion: pc %h at cycle %0d, required none", instruction_o.pc, cyc);
      end else begin
        c = exp_cmp_q.pop_front();
        chk("cmp_pc", instruction_o.pc, c.pc);
        chk("cmp_rd", instruction_o.rd, c.rd);
        chk("cmp_prd", instruction_o.prd, c.prd);
        chk("cmp_gl_index", instruction_o.gl_index, c.gl);
        chk("cmp_chkp", instruction_o.chkp, c.chkp);
        chk("cmp_checkpoint_done", instruction_o.checkpoint_done, c.cd);
        chk("cmp_instr_type", instruction_o.instr_type, PQC_ZETA_WR);
        chk("cmp_result", instruction_o.result, 0);
        chk("cmp_regfile_we", instruction_o.regfile_we, 0);
        chk("cmp_branch_taken", instruction_o.branch_taken, 0);
        chk("cmp_fp_status", instruction_o.fp_status, 0);
        chk("cmp_ex_valid", instruction_o.ex.valid, c.exv);
        if (c.exv) chk("cmp_ex_cause", instruction_o.ex.cause, ST_AMO_ACCESS_FAULT);
        chk("cmp_ex_origin", instruction_o.ex.origin, c.origin);
        chk("cmp_cycle", cyc, c.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rr_exe_arith_instr_t x, b;
    int k, k1, k2, w, pos;
    logic [63:0] rs2;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_we", we_zeta_o, 0);
    chk("rst_valid", instruction_o.valid, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_addr", zeta_addr_o, 0);
    chk("rst_data", zeta_data_o, 0);
    @(negedge clk);
    rstn_i = 1;
    @(negedge clk);
    chk("ready_after_reset", ready_o, 1);

    // Basic two-word write
    issue(mk(64'hAAAA_BBBB_CCCC_DDDD, 64'h0000_0003_0000_0010, 64'h8000_1000, UNIT_PQC_NTT, PQC_ZETA_WR), 1, k, w);
    @(negedge clk);
    // Index wrap at 0xFF inside bank 5
    issue(mk(64'h0123_4567_89AB_CDEF, 64'h0000_0005_0000_00FF, 64'h8000_1004, UNIT_PQC_NTT, PQC_ZETA_WR), 1, k, w);
    @(negedge clk);
    // Illegal address: fault completion, no writes
    issue(mk(64'h5555_6666_7777_8888, 64'h0000_0000_0000_0100, 64'h8000_1008, UNIT_PQC_NTT, PQC_ZETA_WR), 1, k, w);
    @(negedge clk);

    // Asynchronous reset while in WR_LO
    issue(mk(64'h1111_2222_3333_4444, 64'h0000_0001_0000_0020, 64'h8000_100C, UNIT_PQC_NTT, PQC_ZETA_WR), 0, k, w);
    @(negedge clk);
    rstn_i = 0;
    #1;
    chk("rst_mid_we", we_zeta_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_valid", instruction_o.valid, 0);
    repeat (2) @(negedge clk);
    rstn_i = 1;
    repeat (3) @(negedge clk);

    // Flush during WR_HI: low write stays, high write gated, no completion
    issue(mk(64'h9999_0000_1234_5678, 64'h0000_0002_0000_0040, 64'h8000_1010, UNIT_PQC_NTT, PQC_ZETA_WR), 2, k, w);
    @(negedge clk);
    @(negedge clk);
    flush_i = 1;
    #1 chk("flush_we_gate", we_zeta_o, 0);
    @(negedge clk);
    chk("flush_ready_next", ready_o, 1);
    flush_i = 0;

    // Flush together with a valid instruction: not accepted
    in_i = mk(64'hDEAD_BEEF_0000_0001, 64'h0000_0001_0000_0001, 64'h8000_1014, UNIT_PQC_NTT, PQC_ZETA_WR);
    flush_i = 1;
    @(negedge clk);
    chk("flush_blocks_accept", busy_o, 0);
    flush_i = 0;

    // Non-matching instructions in IDLE are ignored
    in_i = mk(64'h1, 64'h0, 64'h8000_1018, UNIT_ALU, PQC_ZETA_WR);
    @(negedge clk);
    chk("ignore_unit", busy_o, 0);
    in_i = mk(64'h2, 64'h0, 64'h8000_101C, UNIT_PQC_NTT, ADD);
    @(negedge clk);
    chk("ignore_type", busy_o, 0);
    x = mk(64'h3, 64'h0, 64'h8000_1020, UNIT_PQC_NTT, PQC_ZETA_WR);
    x.instr.valid = 1'b0;
    in_i = x;
    @(negedge clk);
    chk("ignore_invalid", busy_o, 0);
    in_i = '0;

    // Back-to-back issue with foreign instructions while busy
    issue(mk({$urandom, $urandom}, 64'h0000_0007_0000_0033, 64'h8000_2000, UNIT_PQC_NTT, PQC_ZETA_WR), 1, k1, w);
    @(negedge clk);
    chk("busy_during_seq", busy_o, 1);
    in_i = mk({$urandom, $urandom}, 64'h0000_0008_0000_0001, 64'h8000_2004, UNIT_ALU, ADD);
    @(negedge clk);
    in_i = mk({$urandom, $urandom}, 64'h0000_0009_0000_0002, 64'h8000_2008, UNIT_PQC_NTT, PQC_NTT_BFU);
    @(negedge clk);
    b = mk({$urandom, $urandom}, 64'h0000_000A_0000_0044, 64'h8000_200C, UNIT_PQC_NTT, PQC_ZETA_WR);
    issue(b, 1, k2, w);
    chk("b2b_second_start", k2, k1 + 4);
    chk("b2b_held_off", w > 0, 1);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        in_i = mk({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, UNIT_MEM, PQC_ZETA_WR);
        @(negedge clk);
      end
      rs2 = {$urandom, $urandom};
      if ($urandom_range(0, 9) < 7) rs2 &= 64'h0000_00FF_0000_00FF;
      else begin
        pos = $urandom_range(0, 47);
        pos = pos < 24 ? pos + 8 : pos + 16;
        rs2 |= 64'd1 << pos;
      end
      issue(mk({$urandom, $urandom}, rs2, {32'h8000_0000, $urandom} & ~64'd3, UNIT_PQC_NTT, PQC_ZETA_WR), 1, k, w);
    end

    repeat (8) @(negedge clk);
    chk("writes_drained", exp_wr_q.size(), 0);
    chk("completions_drained", exp_cmp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
